multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
// - Main control FSM for the multi-cycle RV32I core: sequences the shared ALU, register file, IR/PC and unified memory
//   port over 3-5 cycles per instruction. Emits alu_op to the downstream ALU decoder; does not decode funct3/funct7.
// - Supports lw, sw, R-type, I-type ALU, beq, jal. Stalls on a ready handshake with memory.
// PARAMETERS
// - MEM_TIMEOUT  default 255  max wait cycles for mem_ready per access; 0 = no timeout
// - PERF_CNT_W   default 32   width of the retired-instruction counter (optional feature only)
// PORTS
// - clk          in   1   single clock, rising edge
// - rst_n        in   1   asynchronous, active-low reset
// - op           in   7   opcode from IR; stable from DECODE until next FETCH
// - zero         in   1   ALU zero flag
// - mem_ready    in   1   memory completes the current access this cycle
// - mem_req      out  1   memory access requested
// - mem_write    out  1   write strobe; qualifies mem_req
// - adr_src      out  1   0 = PC, 1 = Result
// - ir_write     out  1   load IR (and OldPC)
// - pc_write     out  1   load PC (pc_update | branch&zero)
// - reg_write    out  1   register file write enable
// - result_src   out  2   00 ALUOut, 01 Data, 10 ALUResult
// - alu_src_a    out  2   00 PC, 01 OldPC, 10 RD1
// - alu_src_b    out  2   00 RD2, 01 ImmExt, 10 const 4
// - alu_op       out  2   00 add, 01 sub (branch), 10 funct-decoded
// - illegal_instr out 1   sticky; unsupported opcode seen
// - bus_fault    out  1   sticky; memory timeout
// - instret      out  PERF_CNT_W   retired count (CTRL_PERF_CNT_EN only)
// BEHAVIOUR
// - Moore outputs decoded from the registered state, except ir_write/pc_write in FETCH, which are gated by mem_ready.
// - Reset: state=IDLE; every output 0 (instret=0). IDLE -> FETCH unconditionally on the next clock.
// - FETCH: mem_req, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10. Stays while !mem_ready.
//   On mem_ready: ir_write=1, pc_write=1, then -> DECODE.
// - DECODE: src_a=01, src_b=01, alu_op=00 (branch target into ALUOut). Next state by op:
//   0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; else -> ILLEGAL.
// - MEMADR: src_a=10, src_b=01, alu_op=00. Next: MEMREAD if op[5]=0, else MEMWRITE.
// - MEMREAD: mem_req, adr_src=1, result_src=00. Waits for mem_ready, then -> MEMWB.
// - MEMWRITE: mem_req, mem_write, adr_src=1, result_src=00. Waits for mem_ready, then -> FETCH.
// - MEMWB: result_src=01, reg_write=1. -> FETCH.
// - EXECR: src_a=10, src_b=00, alu_op=10. EXECI: src_a=10, src_b=01, alu_op=10. Both -> ALUWB.
// - ALUWB: result_src=00, reg_write=1. -> FETCH.
// - BEQ: src_a=10, src_b=00, alu_op=01, result_src=00, pc_write=zero. -> FETCH.
// - JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_write=1. -> ALUWB (writes PC+4 to rd).
// - Timeout: wait counter clears on entry to each mem state and increments every !mem_ready cycle. When MEM_TIMEOUT!=0
//   and count==MEM_TIMEOUT with mem_ready still 0 -> FAULT. mem_ready on the same cycle wins over timeout.
// - ILLEGAL and FAULT are terminal until reset. All enables are 0 there; illegal_instr / bus_fault are held at 1.
// - Latency, zero wait: beq 3; R/I/sw 4; jal 4; lw 5 cycles.
// - rst_n assertion mid-instruction: immediate return to IDLE; no partial write enables are asserted afterwards.
// - Unlisted outputs are 0 in each state.
// CONFIGURATION
// - CTRL_PERF_CNT_EN defined: instret increments by 1 on each retirement, in the last state of an instruction.
//   Retirement states: MEMWRITE completes, MEMWB, ALUWB, BEQ. JAL retires via ALUWB only. Wraps modulo 2^PERF_CNT_W.
// - CTRL_PERF_CNT_EN undefined: the port is absent and no counter logic is built.
// STRUCTURE
// - Package ctrl_pkg: state enum (4-bit: IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB,
//   BEQ, JAL, ILLEGAL, FAULT), opcode constants, and the encodings of result_src / alu_src_a / alu_src_b / alu_op.
// - One sub-module: ctrl_mem_timer (wait counter + timeout compare), reused on all three memory states.
// TESTING
// - Reset, then release, mem_ready=1 -> IDLE 1 cycle; FETCH with ir_write=pc_write=1; DECODE next.
// - op=0000011 (lw), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in MEMWB.
//   With mem_ready low 3 cycles in MEMREAD, total latency is 8.
// - op=1100011: zero=1 gives pc_write=1 in BEQ; zero=0 gives pc_write=0. Both return to FETCH after 3 cycles.
// - op=1111111 -> ILLEGAL, illegal_instr=1 held; all enables 0 for 20 cycles; rst_n low returns to IDLE.
// - MEM_TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 5 wait cycles, bus_fault=1.
//   mem_ready=1 on the 5th cycle gives normal DECODE instead.
// - CTRL_PERF_CNT_EN: run sw, add, jal, beq -> instret=4; rst_n mid-lw -> instret=0, state IDLE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BEQ,
      S_JAL,
      S_ILLEGAL,
      S_FAULT
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Memory wait counter with terminal-count compare; shared by all memory-access states.
module ctrl_mem_timer
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic mem_ready,
   output logic timeout
);

   localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

   logic [CW-1:0] count;

   // Cleared outside memory states and on completion, so every access starts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!active || mem_ready) begin
         count <= '0;
      end else if (count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   assign timeout = (MEM_TIMEOUT != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core; CTRL_PERF_CNT_EN adds the instret counter.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int PERF_CNT_W  = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       adr_src,
   output logic       ir_write,
   output logic       pc_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       illegal_instr,
   output logic       bus_fault
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0] instret
`endif
);

   // state    | meaning
   // IDLE     | after reset, one cycle
   // FETCH    | read instruction at PC, PC+4 into PC
   // DECODE   | branch/jump target into ALUOut, dispatch on opcode
   // MEMADR   | rs1 + imm address for lw/sw
   // MEMREAD  | load data read
   // MEMWB    | load data into rd
   // MEMWRITE | store data write
   // EXECR    | R-type ALU op
   // EXECI    | I-type ALU op
   // ALUWB    | ALUOut into rd (ALU ops and jal link)
   // BEQ      | compare, PC <= target if equal
   // JAL      | PC <= target, PC+4 computed for link
   // ILLEGAL  | unsupported opcode, terminal
   // FAULT    | memory timeout, terminal

   state_t state_q, state_d;
   logic   timeout;

   ctrl_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .active    (is_mem_state(state_q)),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      adr_src       = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      result_src    = RES_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RD2;
      alu_op        = ALUOP_ADD;
      illegal_instr = 1'b0;
      bus_fault     = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALURESULT;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready)    state_d = S_MEMWB;
            else if (timeout) state_d = S_FAULT;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready)    state_d = S_FETCH;
            else if (timeout) state_d = S_FAULT;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a = SRCA_RD1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a = SRCA_RD1;
            alu_op    = ALUOP_SUB;
            pc_write  = zero;
            state_d   = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ILLEGAL: illegal_instr = 1'b1;
         S_FAULT:   bus_fault     = 1'b1;
         default:   state_d       = S_IDLE;
      endcase
   end

`ifdef CTRL_PERF_CNT_EN
   logic retire;

   // jal is counted in ALUWB only, so JAL itself is not a retirement state.
   assign retire = ((state_q == S_MEMWRITE) && mem_ready) || (state_q == S_MEMWB) ||
                   (state_q == S_ALUWB) || (state_q == S_BEQ);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret <= '0;
      else if (retire) instret <= instret + 1'b1;
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm (MEM_TIMEOUT=4); checks instret when CTRL_PERF_CNT_EN is defined.
module tb_multicycle_ctrl_fsm;

   localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMREAD = 4,
                  P_MEMWB = 5, P_MEMWRITE = 6, P_EXECR = 7, P_EXECI = 8, P_ALUWB = 9,
                  P_BEQ = 10, P_JAL = 11, P_ILLEGAL = 12, P_FAULT = 13;

   typedef struct {
      logic [15:0] v;
      logic [31:0] ret;
      int          ph;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic       illegal_instr, bus_fault;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instret;
`endif

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_slot = 0;
   logic [31:0] model_ret = 0;

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .PERF_CNT_W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op            (op),
      .zero          (zero),
      .mem_ready     (mem_ready),
      .mem_req       (mem_req),
      .mem_write     (mem_write),
      .adr_src       (adr_src),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .reg_write     (reg_write),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .illegal_instr (illegal_instr),
      .bus_fault     (bus_fault)
`ifdef CTRL_PERF_CNT_EN
      ,
      .instret       (instret)
`endif
   );

   always #5 clk = ~clk;

   // Expected outputs of one cycle, straight from the per-phase output list.
   function automatic logic [15:0] outs(input int ph, input logic rdy, input logic z);
      logic mr = 0, mw = 0, as = 0, iw = 0, pw = 0, rw = 0, il = 0, bf = 0;
      logic [1:0] rs = 0, sa = 0, sb = 0, ao = 0;
      case (ph)
         P_FETCH:    begin mr = 1; sb = 2'b10; rs = 2'b10; iw = rdy; pw = rdy; end
         P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
         P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         P_MEMREAD:  begin mr = 1; as = 1; end
         P_MEMWRITE: begin mr = 1; mw = 1; as = 1; end
         P_MEMWB:    begin rs = 2'b01; rw = 1; end
         P_EXECR:    begin sa = 2'b10; ao = 2'b10; end
         P_EXECI:    begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
         P_ALUWB:    rw = 1;
         P_BEQ:      begin sa = 2'b10; ao = 2'b01; pw = z; end
         P_JAL:      begin sa = 2'b01; sb = 2'b10; pw = 1; end
         P_ILLEGAL:  il = 1;
         P_FAULT:    bf = 1;
         default:    ;
      endcase
      return {mr, mw, as, iw, pw, rw, rs, sa, sb, ao, il, bf};
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic slot(input int ph, input logic rdy, input logic z);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      mem_ready = rdy;
      zero      = z;
      e.v   = outs(ph, rdy, z);
      e.ret = model_ret;
      e.ph  = ph;
      q.push_back(e);
      if (ph == P_MEMWB || ph == P_ALUWB || ph == P_BEQ || (ph == P_MEMWRITE && rdy))
         model_ret = model_ret + 1;
   endtask

   task automatic rst_slot();
      exp_t e;
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = rb();
      model_ret = 0;
      e.v   = outs(P_IDLE, 1'b0, 1'b0);
      e.ret = 0;
      e.ph  = P_IDLE;
      q.push_back(e);
   endtask

   task automatic do_reset();
      rst_slot();
      rst_slot();
      slot(P_IDLE, rb(), rb());
   endtask

   task automatic fetch(input logic [6:0] o, input int stalls);
      op = o;
      for (int i = 0; i < stalls; i++) slot(P_FETCH, 1'b0, rb());
      slot(P_FETCH, 1'b1, rb());
      slot(P_DECODE, rb(), rb());
   endtask

   task automatic run_instr(input logic [6:0] o, input logic z, input int sf, input int sm);
      fetch(o, sf);
      case (o)
         7'b0000011: begin
            slot(P_MEMADR, rb(), rb());
            for (int i = 0; i < sm; i++) slot(P_MEMREAD, 1'b0, rb());
            slot(P_MEMREAD, 1'b1, rb());
            slot(P_MEMWB, rb(), rb());
         end
         7'b0100011: begin
            slot(P_MEMADR, rb(), rb());
            for (int i = 0; i < sm; i++) slot(P_MEMWRITE, 1'b0, rb());
            slot(P_MEMWRITE, 1'b1, rb());
         end
         7'b0110011: begin slot(P_EXECR, rb(), rb()); slot(P_ALUWB, rb(), rb()); end
         7'b0010011: begin slot(P_EXECI, rb(), rb()); slot(P_ALUWB, rb(), rb()); end
         7'b1100011: slot(P_BEQ, rb(), z);
         7'b1101111: begin slot(P_JAL, rb(), rb()); slot(P_ALUWB, rb(), rb()); end
         default: slot(P_ILLEGAL, rb(), rb());
      endcase
   endtask

   always @(negedge clk) begin
      logic [15:0] act;
      exp_t        e;
      if (q.size() > 0) begin
         e   = q.pop_front();
         act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, illegal_instr, bus_fault};
         n_checks++;
         if (act !== e.v) begin
            n_errors++;
            $display("FAIL outputs slot %0d phase %0d: got %h expected %h", n_slot, e.ph, act, e.v);
         end
`ifdef CTRL_PERF_CNT_EN
         n_checks++;
         if (instret !== e.ret) begin
            n_errors++;
            $display("FAIL instret slot %0d: got %0d expected %0d", n_slot, instret, e.ret);
         end
`endif
         n_slot++;
      end
   end

   initial begin
      logic [6:0] ops [6];
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

      do_reset();
      run_instr(7'b0000011, 1'b0, 0, 0);
      run_instr(7'b0000011, 1'b0, 0, 3);
      run_instr(7'b1100011, 1'b1, 0, 0);
      run_instr(7'b1100011, 1'b0, 0, 0);
      run_instr(7'b0100011, 1'b0, 4, 4);

      do_reset();
      run_instr(7'b0100011, 1'b0, 0, 0);
      run_instr(7'b0110011, 1'b0, 0, 0);
      run_instr(7'b1101111, 1'b0, 0, 0);
      run_instr(7'b1100011, 1'b1, 0, 0);

      for (int n = 0; n < 80; n++)
         run_instr(ops[$urandom_range(0, 5)], rb(), $urandom_range(0, 4), $urandom_range(0, 4));

      // reset in the middle of a stalled load
      fetch(7'b0000011, 0);
      slot(P_MEMADR, rb(), rb());
      slot(P_MEMREAD, 1'b0, rb());
      slot(P_MEMREAD, 1'b0, rb());
      do_reset();
      run_instr(7'b0000011, 1'b0, 1, 2);

      // unsupported opcode is terminal
      fetch(7'b1111111, 0);
      for (int i = 0; i < 20; i++) slot(P_ILLEGAL, rb(), rb());
      do_reset();

      // fetch timeout: five unanswered cycles
      op = 7'b0110011;
      for (int i = 0; i < 5; i++) slot(P_FETCH, 1'b0, rb());
      for (int i = 0; i < 6; i++) slot(P_FAULT, rb(), rb());
      do_reset();

      // load timeout after a normal instruction
      run_instr(7'b0010011, 1'b0, 2, 0);
      fetch(7'b0000011, 0);
      slot(P_MEMADR, rb(), rb());
      for (int i = 0; i < 5; i++) slot(P_MEMREAD, 1'b0, rb());
      for (int i = 0; i < 4; i++) slot(P_FAULT, rb(), rb());
      do_reset();
      run_instr(7'b1100011, 1'b1, 0, 0);

      @(posedge clk);
      @(posedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
